// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO).
// Optional macro MULDIV_FAST_MUL_EN: multiply completes combinationally at accept; divide stays iterative.
module ex_muldiv_unit #(
    parameter int BUS_SIZE = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic [5:0]          i_op,
    input  logic [5:0]          i_funct,
    input  logic [BUS_SIZE-1:0] i_bus_a,
    input  logic [BUS_SIZE-1:0] i_bus_b,
    output logic                o_stall,
    output logic                o_busy,
    output logic [BUS_SIZE-1:0] o_result,
    output logic [BUS_SIZE-1:0] o_hi,
    output logic [BUS_SIZE-1:0] o_lo
);
    localparam int CW = $clog2(BUS_SIZE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q;
    logic [BUS_SIZE-1:0] hi_q, lo_q;
    logic [BUS_SIZE-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic [CW-1:0]       cnt_q;
    logic                is_div_q, neg_q, rneg_q, div0_q;

    logic                  dec_start, dec_mthi, dec_mtlo, sign_a, sign_b;
    logic [BUS_SIZE-1:0]   mag_a, mag_b;
    logic [BUS_SIZE-1:0]   acc_hi_d, acc_lo_d, res_hi_d, res_lo_d;
    logic [BUS_SIZE:0]     rem_sh;
    logic [2*BUS_SIZE-1:0] prod;

    assign dec_start = (i_op == 6'h00) && (i_funct[5:2] == 4'b0110);
    assign dec_mthi  = (i_op == 6'h00) && (i_funct == 6'h11);
    assign dec_mtlo  = (i_op == 6'h00) && (i_funct == 6'h13);
    assign sign_a    = dec_start && !i_funct[0] && i_bus_a[BUS_SIZE-1];
    assign sign_b    = dec_start && !i_funct[0] && i_bus_b[BUS_SIZE-1];
    assign mag_a     = sign_a ? -i_bus_a : i_bus_a;
    assign mag_b     = sign_b ? -i_bus_b : i_bus_b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*BUS_SIZE-1:0] fast_prod;
    assign fast_prod = {{BUS_SIZE{1'b0}}, mag_a} * {{BUS_SIZE{1'b0}}, mag_b};
`else
    logic [BUS_SIZE:0] sum;
`endif

    // One radix-2 step: restoring shift-subtract for divide, shift-add for multiply.
    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        rem_sh   = {acc_hi_q, acc_lo_q[BUS_SIZE-1]};
`ifndef MULDIV_FAST_MUL_EN
        sum      = '0;
`endif
        if (is_div_q) begin
            acc_lo_d = {acc_lo_q[BUS_SIZE-2:0], (rem_sh >= {1'b0, opnd_q})};
            if (rem_sh >= {1'b0, opnd_q})
                acc_hi_d = BUS_SIZE'(rem_sh - {1'b0, opnd_q});
            else
                acc_hi_d = rem_sh[BUS_SIZE-1:0];
        end else begin
`ifndef MULDIV_FAST_MUL_EN
            sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
            {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[BUS_SIZE-1:1]};
`endif
        end
    end

    assign prod = neg_q ? -{acc_hi_d, acc_lo_d} : {acc_hi_d, acc_lo_d};

    always_comb begin
        if (is_div_q) begin
            res_lo_d = div0_q ? '1 : (neg_q ? -acc_lo_d : acc_lo_d);
            res_hi_d = rneg_q ? -acc_hi_d : acc_hi_d;
        end else begin
            {res_hi_d, res_lo_d} = prod;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else if (i_flush) begin
            state_q <= IDLE;
        end else if (i_enable) begin
            case (state_q)
                IDLE: begin
                    if (dec_start) begin
                        state_q  <= BUSY;
                        is_div_q <= i_funct[1];
                        neg_q    <= sign_a ^ sign_b;
                        rneg_q   <= sign_a;
                        div0_q   <= (i_bus_b == '0);
                        if (i_funct[1]) begin
                            opnd_q   <= mag_b;
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_a;
                            cnt_q    <= CW'(BUS_SIZE-1);
                        end else begin
                            opnd_q <= mag_a;
`ifdef MULDIV_FAST_MUL_EN
                            {acc_hi_q, acc_lo_q} <= fast_prod;
                            cnt_q                <= '0;
`else
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_b;
                            cnt_q    <= CW'(BUS_SIZE-1);
`endif
                        end
                    end else if (dec_mthi) begin
                        hi_q <= i_bus_a;
                    end else if (dec_mtlo) begin
                        lo_q <= i_bus_a;
                    end
                end
                BUSY: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_stall = ((state_q == IDLE) && dec_start) || (state_q == BUSY);
    assign o_busy  = (state_q == BUSY);
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

    always_comb begin
        o_result = '0;
        if (i_op == 6'h00 && i_funct == 6'h10)
            o_result = hi_q;
        else if (i_op == 6'h00 && i_funct == 6'h12)
            o_result = lo_q;
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table, random vectors against a behavioural model,
// and hand-written flush / enable-hold / mid-operation reset sequences.
module tb_ex_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [5:0] F_NOP   = 6'h00;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic         clk = 1'b0;
    logic         rst_n, en, flush;
    logic [5:0]   op, funct;
    logic [W-1:0] bus_a, bus_b;
    logic         o_stall, o_busy;
    logic [W-1:0] o_result, o_hi, o_lo;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.BUS_SIZE(W)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_flush(flush),
        .i_op(op), .i_funct(funct), .i_bus_a(bus_a), .i_bus_b(bus_b),
        .o_stall(o_stall), .o_busy(o_busy), .o_result(o_result),
        .o_hi(o_hi), .o_lo(o_lo)
    );

    typedef struct { logic [5:0] f; logic [W-1:0] a, b, hi, lo; } vec_t;
    typedef struct { logic [W-1:0] hi, lo; int stall; } exp_t;

    vec_t         tbl [14];
    exp_t         sb [$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] cur_hi, cur_lo;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic int stall_len(input logic [5:0] f);
        return (FAST && !f[1]) ? 2 : W + 1;
    endfunction

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        int              q, r;
        logic [31:0]     uq, ur;
        case (f)
            F_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            F_MULTU: begin
                up = {32'h0, x} * {32'h0, y};
                return up;
            end
            F_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                uq = x / y;
                ur = x % y;
                return {ur, uq};
            end
        endcase
    endfunction

    // Issues one mul/div, holds it while stalled, optionally drops enable for hold_len cycles.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input int hold_at, input int hold_len, input string nm);
        exp_t e;
        int   cyc;
        e.hi = hi;
        e.lo = lo;
        e.stall = stall_len(f) + hold_len;
        sb.push_back(e);
        op = 6'h00; funct = f; bus_a = a; bus_b = b;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (!o_stall) break;
            cyc++;
            if (cyc > 300) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: stall still high after %0d cycles", nm, cyc);
                break;
            end
            @(posedge clk); #1;
            if (hold_len > 0 && cyc == hold_at) en = 1'b0;
            if (hold_len > 0 && cyc == hold_at + hold_len) en = 1'b1;
        end
        e = sb.pop_front();
        check({nm, " stall_cycles"}, W'(cyc), W'(e.stall));
        check({nm, " hi"}, o_hi, e.hi);
        check({nm, " lo"}, o_lo, e.lo);
        check({nm, " busy_in_done"}, W'(o_busy), '0);
        cur_hi = e.hi;
        cur_lo = e.lo;
        @(posedge clk); #1;
        funct = F_NOP;
    endtask

    task automatic read_check(input logic [5:0] f, input logic [W-1:0] exp, input string nm);
        op = 6'h00; funct = f;
        @(negedge clk);
        check({nm, " result"}, o_result, exp);
        check({nm, " stall"}, W'(o_stall), '0);
        @(posedge clk); #1;
        funct = F_NOP;
    endtask

    task automatic write_op(input logic [5:0] f, input logic [W-1:0] val, input string nm);
        op = 6'h00; funct = f; bus_a = val;
        @(negedge clk);
        check({nm, " stall"}, W'(o_stall), '0);
        @(posedge clk); #1;
        funct = F_NOP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  rf;
        logic [31:0] rx, ry;
        logic [63:0] m;

        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        op = 6'h00; funct = F_MFHI; bus_a = '0; bus_b = '0;
        cur_hi = '0; cur_lo = '0;

        tbl[0]  = '{F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[1]  = '{F_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{F_DIV,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        tbl[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5]  = '{F_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        tbl[6]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        tbl[7]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[8]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[9]  = '{F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[10] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[11] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF};
        tbl[12] = '{F_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
        tbl[13] = '{F_MULT,  32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};

        #2;
        check("reset hi", o_hi, '0);
        check("reset lo", o_lo, '0);
        check("reset stall", W'(o_stall), '0);
        check("reset busy", W'(o_busy), '0);
        check("reset result", o_result, '0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        funct = F_NOP;

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 0, 0, $sformatf("vec%0d", i));
            if (i == 0) begin
                read_check(F_MFHI, 32'h0000_0001, "mfhi_after_multu");
                read_check(F_MFLO, 32'hFFFF_FFFE, "mflo_after_multu");
            end
        end

        for (int i = 0; i < 10; i++) begin
            rf = F_MULT + 6'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'h0;
                1:       ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            m = model(rf, rx, ry);
            run_op(rf, rx, ry, m[63:32], m[31:0], 0, 0, $sformatf("rand%0d", i));
        end

        write_op(F_MTHI, 32'hA5A5_A5A5, "mthi");
        read_check(F_MFHI, 32'hA5A5_A5A5, "mfhi_after_mthi");
        write_op(F_MTLO, 32'h5A5A_5A5A, "mtlo");
        read_check(F_MFLO, 32'h5A5A_5A5A, "mflo_after_mtlo");
        cur_hi = 32'hA5A5_A5A5;
        cur_lo = 32'h5A5A_5A5A;

        // Flush at BUSY cycle 10: HI/LO must keep their pre-operation values.
        op = 6'h00; funct = F_MULTU; bus_a = 32'd3; bus_b = 32'd5;
        @(negedge clk);
        check("flush accept stall", W'(o_stall), 32'h1);
        @(posedge clk); #1;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                check("busy flag", W'(o_busy), 32'h1);
                check("busy old hi", o_hi, cur_hi);
                check("non-mf result zero", o_result, '0);
            end
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        funct = F_NOP;
        @(negedge clk);
        check("flush stall", W'(o_stall), '0);
        check("flush busy", W'(o_busy), '0);
        check("flush hi", o_hi, cur_hi);
        check("flush lo", o_lo, cur_lo);
        @(posedge clk); #1;

        run_op(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5, 5, "div_enable_hold");

        // Asynchronous reset in the middle of an operation.
        op = 6'h00; funct = F_MULTU; bus_a = 32'hFFFF_FFFF; bus_b = 32'hFFFF_FFFF;
        @(negedge clk);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midop reset hi", o_hi, '0);
        check("midop reset lo", o_lo, '0);
        check("midop reset busy", W'(o_busy), '0);
        funct = F_NOP;
        #1;
        check("midop reset stall", W'(o_stall), '0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        read_check(F_MFLO, 32'h0, "mflo_after_reset");
        run_op(tbl[1].f, tbl[1].a, tbl[1].b, tbl[1].hi, tbl[1].lo, 0, 0, "post_reset_mult");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, fed directly from the ID/EX pipeline register outputs (operand buses, op, funct). It executes MULT/MULTU/DIV/DIVU over multiple cycles while stalling the front of the pipeline. It owns the HI/LO architectural registers and serves MFHI/MFLO/MTHI/MTLO. Its result joins the EX result mux alongside the ALU.

Parameters:
BUS_SIZE, 32, operand/HI/LO width; must be even, at least 4.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_enable  in  1  pipeline enable from the debug unit; low freezes all state.
i_flush  in  1  synchronous abort of an in-flight operation.
i_op  in  6  opcode from ID/EX.
i_funct  in  6  funct from ID/EX.
i_bus_a  in  BUS_SIZE  rs operand (forwarded).
i_bus_b  in  BUS_SIZE  rt operand (forwarded).
o_stall  out  1  stalls PC, IF/ID and ID/EX; inserts a bubble into EX/MEM.
o_busy  out  1  high while state is BUSY.
o_result  out  BUS_SIZE  HI for MFHI, LO for MFLO, otherwise 0.
o_hi  out  BUS_SIZE  HI register, for debug readout.
o_lo  out  BUS_SIZE  LO register, for debug readout.

Behaviour:
- Decode: the block acts only when i_op is 6'h00.
  - funct 6'h18 MULT, 6'h19 MULTU, 6'h1A DIV, 6'h1B DIVU: start an operation.
  - funct 6'h10 MFHI, 6'h12 MFLO: read.
  - funct 6'h11 MTHI, 6'h13 MTLO: write.
  - Any other op/funct: no effect.
- Reset (i_reset low, async): state IDLE, HI=0, LO=0, counter=0, internal operands 0. o_stall=0, o_busy=0, o_result=0.
- FSM states: IDLE, BUSY, DONE. All transitions are gated by i_enable; with i_enable low, nothing changes.
- IDLE:
  - A start funct moves to BUSY. The block latches operands as magnitudes, records the result signs (signed ops only) and sets counter=BUS_SIZE-1.
  - MTHI loads HI<=i_bus_a; MTLO loads LO<=i_bus_a, in one cycle.
- BUSY:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements each cycle. At counter==0 the block applies sign correction, writes HI/LO and moves to DONE.
  - BUSY therefore lasts exactly BUS_SIZE cycles.
- DONE:
  - Lasts one cycle; o_stall=0 so the mul/div instruction leaves EX.
  - A start funct is ignored in this cycle because it is the same instruction. Next state is IDLE.
- o_stall (combinational) = (IDLE and start funct decoded) or BUSY. A mul/div therefore stalls the pipeline for BUS_SIZE+1 cycles.
- Multiply results: HI:LO = full 2*BUS_SIZE-bit product. Signed ops use two's complement.
- Divide results: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend. Applies to both signed and unsigned; no exception.
- Signed overflow (most-negative value / -1): LO = most-negative value, HI = 0.
- o_result is combinational from current HI/LO. While BUSY, the old HI/LO are visible. In DONE, the new values are visible.
- i_flush is synchronous and has priority over i_enable:
  - BUSY or DONE abort to IDLE, and HI/LO keep their pre-operation values.
  - A pending start or MTHI/MTLO in the same cycle is discarded.
- Reset asserted mid-operation clears everything immediately. There is no partial write.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU compute the product combinationally in the accept cycle. BUSY lasts 1 cycle, so the total stall is 2 cycles. Divide is unchanged.
- Undefined: all operations are iterative as described above.

Test Plan:
- MULTU: i_bus_a=32'hFFFF_FFFF, i_bus_b=32'h2 -> o_stall high for 33 cycles; then HI=32'h1, LO=32'hFFFF_FFFE; MFHI gives o_result=1.
- MULT: a=-7 (32'hFFFF_FFF9), b=3 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIV: a=-7, b=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIV by zero: a=32'h1234, b=0 -> LO=32'hFFFF_FFFF, HI=32'h1234. Overflow case a=32'h8000_0000, b=-1 -> LO=32'h8000_0000, HI=0.
- MTHI 32'hA5A5_A5A5 followed by MFHI -> o_result=32'hA5A5_A5A5 with no stall.
- Mid-op events:
  - i_flush at BUSY cycle 10 -> IDLE next cycle, HI/LO unchanged, o_stall=0.
  - i_enable low for 5 cycles during BUSY -> total stall extended by 5 cycles.
  - i_reset low mid-op -> HI=LO=0 immediately.
